// File: rtl/max_pool_ctrl.sv
// max_pool_ctrl
//   Sequencer for a combinational max-pooling datapath. Collects one
//   ARRAY_WIDTH x ARRAY_WIDTH input tile (row-major) from a valid/ready stream
//   into a register buffer. The buffer drives the pooling datapath directly.
//   The controller then captures the pooled result and streams the
//   RESULT_WIDTH x RESULT_WIDTH values out, one per handshake.
//
// Ports
//   clk, rst      clock; synchronous active-high reset
//   start         begin one tile (only honoured while idle)
//   abort         return to idle from any state; no done pulse
//   in_valid/in_data/in_ready      input element stream
//   pool_in_vec   flattened input buffer, element i at [i*DW +: DW]
//   pool_result   flattened pooled result from the datapath
//   out_valid/out_data/out_ready   pooled element stream, row-major
//   out_last      out_valid on the final pooled element
//   busy          controller not idle
//   done          one-cycle pulse after the last output handshake
module max_pool_ctrl #(
  parameter int IP_DATA_WIDTH = 15,
  parameter int ARRAY_WIDTH   = 4,
  parameter int RESULT_WIDTH  = 2,
  localparam int DW    = IP_DATA_WIDTH + 1,
  localparam int N_IN  = ARRAY_WIDTH * ARRAY_WIDTH,
  localparam int N_OUT = RESULT_WIDTH * RESULT_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic                in_valid,
  input  logic [DW-1:0]       in_data,
  output logic                in_ready,
  output logic [N_IN*DW-1:0]  pool_in_vec,
  input  logic [N_OUT*DW-1:0] pool_result,
  output logic                out_valid,
  output logic [DW-1:0]       out_data,
  input  logic                out_ready,
  output logic                out_last,
  output logic                busy,
  output logic                done
);

  localparam int IW = $clog2(N_IN + 1);
  localparam int OW = $clog2(N_OUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_COMPUTE,
    S_DRAIN
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] in_idx_q, in_idx_d;
  logic [OW-1:0] out_idx_q, out_idx_d;
  logic          done_q, done_d;

  logic [DW-1:0] in_buf_q  [N_IN];
  logic [DW-1:0] res_buf_q [N_OUT];

  logic          in_accept;
  logic          capture;
  logic          is_last;
  logic [DW-1:0] out_sel;

  assign is_last = (out_idx_q == OW'(N_OUT - 1));

  // Next-state logic. Abort is applied last so it overrides every transition
  // and suppresses buffer writes, capture and the done pulse.
  always_comb begin
    state_d   = state_q;
    in_idx_d  = in_idx_q;
    out_idx_d = out_idx_q;
    done_d    = 1'b0;
    in_accept = 1'b0;
    capture   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_LOAD;
          in_idx_d = '0;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          in_accept = 1'b1;
          in_idx_d  = in_idx_q + IW'(1);
          if (in_idx_q == IW'(N_IN - 1)) begin
            state_d = S_COMPUTE;
          end
        end
      end
      S_COMPUTE: begin
        capture   = 1'b1;
        out_idx_d = '0;
        state_d   = S_DRAIN;
      end
      S_DRAIN: begin
        if (out_ready) begin
          out_idx_d = out_idx_q + OW'(1);
          if (is_last) begin
            state_d   = S_IDLE;
            out_idx_d = '0;
            done_d    = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (abort) begin
      state_d   = S_IDLE;
      in_idx_d  = '0;
      out_idx_d = '0;
      done_d    = 1'b0;
      in_accept = 1'b0;
      capture   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      in_idx_q  <= '0;
      out_idx_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_idx_q  <= in_idx_d;
      out_idx_q <= out_idx_d;
      done_q    <= done_d;
    end
  end

  // Input buffer: one register per slot, written when its index is accepted.
  // Slots persist across tiles and aborts; only reset clears them.
  genvar gi;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_in_buf
      always_ff @(posedge clk) begin
        if (rst) begin
          in_buf_q[gi] <= '0;
        end else if (in_accept && (in_idx_q == IW'(gi))) begin
          in_buf_q[gi] <= in_data;
        end
      end
      assign pool_in_vec[gi*DW +: DW] = in_buf_q[gi];
    end

    for (gi = 0; gi < N_OUT; gi++) begin : g_res_buf
      always_ff @(posedge clk) begin
        if (rst) begin
          res_buf_q[gi] <= '0;
        end else if (capture) begin
          res_buf_q[gi] <= pool_result[gi*DW +: DW];
        end
      end
    end
  endgenerate

  // Output element select by compare rather than direct indexing, so the
  // counter width can exceed the index range without truncation concerns.
  always_comb begin
    out_sel = '0;
    for (int i = 0; i < N_OUT; i++) begin
      if (out_idx_q == OW'(i)) begin
        out_sel = res_buf_q[i];
      end
    end
  end

  assign in_ready  = (state_q == S_LOAD);
  assign out_valid = (state_q == S_DRAIN);
  assign out_data  = (state_q == S_DRAIN) ? out_sel : '0;
  assign out_last  = (state_q == S_DRAIN) && is_last;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_max_pool_ctrl.sv
module tb_max_pool_ctrl;

  localparam int DW    = 16;
  localparam int N_IN  = 16;
  localparam int N_OUT = 4;

  logic              clk = 1'b0;
  logic              rst, start, abort, in_valid, out_ready;
  logic [DW-1:0]     in_data;
  logic              in_ready, out_valid, out_last, busy, done;
  logic [DW-1:0]     out_data;
  logic [N_IN*DW-1:0]  pool_in_vec;
  logic [N_OUT*DW-1:0] pool_result;

  always #5 clk = ~clk;

  max_pool_ctrl #(
    .IP_DATA_WIDTH(15),
    .ARRAY_WIDTH  (4),
    .RESULT_WIDTH (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .pool_in_vec(pool_in_vec),
    .pool_result(pool_result),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  // Behavioural 2x2/stride-2 max pooling over the 4x4 buffer.
  function automatic logic [DW-1:0] el(input logic [N_IN*DW-1:0] v, input int idx);
    return v[idx*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] max2(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  always_comb begin
    pool_result = '0;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 2; c++) begin
        pool_result[(r*2+c)*DW +: DW] =
          max2(max2(el(pool_in_vec, (2*r)*4 + 2*c),     el(pool_in_vec, (2*r)*4 + 2*c + 1)),
               max2(el(pool_in_vec, (2*r+1)*4 + 2*c),   el(pool_in_vec, (2*r+1)*4 + 2*c + 1)));
      end
    end
  end

  int checks   = 0;
  int passes   = 0;
  int done_cnt = 0;
  logic [DW:0] sb[$];   // {last, data}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Expected pooled outputs: order 0 = ascending 0..15, 1 = descending 15..0.
  task automatic sb_push(input int order);
    int asc [4];
    int desc[4];
    asc  = '{5, 7, 13, 15};
    desc = '{15, 13, 7, 5};
    for (int k = 0; k < 4; k++) begin
      if (order == 0) sb.push_back({(k == 3), DW'(asc[k])});
      else            sb.push_back({(k == 3), DW'(desc[k])});
    end
  endtask

  // Monitor: pops the scoreboard on every output handshake and checks that
  // a stalled output holds its value.
  initial begin : monitor
    logic          prev_stall;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    logic [DW:0]   e;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (done) done_cnt++;
        if (prev_stall) begin
          check("stall_valid", 32'(out_valid), 32'd1);
          check("stall_data",  32'(out_data),  32'(prev_data));
          check("stall_last",  32'(out_last),  32'(prev_last));
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            $display("FAIL sb_unexpected: got data %0d with no expected entry", out_data);
          end else begin
            e = sb.pop_front();
            $display("out data=%0d last=%0d", out_data, out_last);
            check("out_data", 32'(out_data), 32'(e[DW-1:0]));
            check("out_last", 32'(out_last), 32'(e[DW]));
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic push_elem(input logic [DW-1:0] d);
    bit acc;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int g = 0; g < 50 && !acc; g++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
    end
    check("in_accept", 32'(acc), 32'd1);
  endtask

  // order: 0 ascending, 1 descending, 2 = 100+i pattern
  task automatic send_tile(input int order, input bit gaps, input bit noise,
                           input bit do_start, input int n);
    logic [DW-1:0] d;
    if (do_start) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      d = (order == 0) ? DW'(i) : (order == 1) ? DW'(15 - i) : DW'(100 + i);
      if (gaps && (i % 3 == 1)) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
      start = noise && (i >= 3) && (i <= 5);
      push_elem(d);
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  // mode 0: out_ready=1; mode 1: out_ready pattern 1-0-0-1;
  // mode 2: start pulsed with out_ready=0 for the first cycles
  task automatic drain(input int mode);
    bit got;
    bit pat[4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    got = 1'b0;
    for (int c = 0; c < 100 && !got; c++) begin
      case (mode)
        1:       out_ready = pat[c % 4];
        2: begin start = (c < 3); out_ready = (c >= 3); end
        default: out_ready = 1'b1;
      endcase
      @(negedge clk);
      if (done) got = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    check("done_seen", 32'(got), 32'd1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int  d0;
    int  n;
    bit  saw;
    rst = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last",  32'(out_last),  32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_done",      32'(done),      32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_vec_zero",  32'(pool_in_vec == '0), 32'd1);
    @(posedge clk); #1;

    // 1: ascending tile, no stalls, latency and single done pulse
    d0 = done_cnt;
    out_ready = 1'b1;
    sb_push(0);
    send_tile(0, 1'b0, 1'b0, 1'b1, 16);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 10);
    check("latency", 32'(n), 32'd2);
    drain(0);
    idle(3);
    check("t1_done_once", 32'(done_cnt), 32'(d0 + 1));

    // 2: input gaps and output stalls
    d0 = done_cnt;
    sb_push(0);
    send_tile(0, 1'b1, 1'b0, 1'b1, 16);
    drain(1);
    idle(3);
    check("t2_done_once", 32'(done_cnt), 32'(d0 + 1));

    // 3: descending tile, then start on the done cycle
    d0 = done_cnt;
    sb_push(1);
    send_tile(1, 1'b0, 1'b0, 1'b1, 16);
    drain(0);
    start = 1'b1;
    sb_push(0);
    @(posedge clk); #1;
    start = 1'b0;
    send_tile(0, 1'b0, 1'b0, 1'b0, 16);
    drain(0);
    idle(3);
    check("t3_done_twice", 32'(done_cnt), 32'(d0 + 2));

    // 4: abort after 6 elements, element presented with abort not stored
    d0 = done_cnt;
    send_tile(2, 1'b0, 1'b0, 1'b1, 6);
    in_valid = 1'b1;
    in_data  = DW'(99);
    abort    = 1'b1;
    @(posedge clk); #1;
    abort    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("abort_busy",     32'(busy),     32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    check("abort_slot0",    32'(pool_in_vec[0*DW +: DW]), 32'd100);
    check("abort_slot6",    32'(pool_in_vec[6*DW +: DW]), 32'd6);
    saw = 1'b0;
    repeat (5) begin
      @(negedge clk);
      saw |= out_valid;
    end
    check("abort_no_out", 32'(saw), 32'd0);
    check("abort_no_done", 32'(done_cnt), 32'(d0));
    @(posedge clk); #1;
    sb_push(0);
    send_tile(0, 1'b0, 1'b0, 1'b1, 16);
    drain(0);
    idle(2);
    check("t4_done_once", 32'(done_cnt), 32'(d0 + 1));

    // 5: reset mid-drain after two outputs
    d0 = done_cnt;
    out_ready = 1'b1;
    sb_push(0);
    send_tile(0, 1'b0, 1'b0, 1'b1, 16);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 10);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_data",  32'(out_data),  32'd0);
    check("mid_rst_out_last",  32'(out_last),  32'd0);
    check("mid_rst_busy",      32'(busy),      32'd0);
    check("mid_rst_done",      32'(done),      32'd0);
    check("mid_rst_vec_zero",  32'(pool_in_vec == '0), 32'd1);
    check("mid_rst_remaining", 32'(sb.size()), 32'd2);
    check("mid_rst_no_done",   32'(done_cnt),  32'(d0));
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

    // 6: start pulsed during LOAD and DRAIN is ignored
    d0 = done_cnt;
    sb_push(0);
    send_tile(0, 1'b0, 1'b1, 1'b1, 16);
    drain(2);
    start = 1'b0;
    idle(3);
    check("t6_done_once", 32'(done_cnt), 32'(d0 + 1));
    check("t6_idle",      32'(busy),     32'd0);
    check("sb_drained",   32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
